// File: rtl/spi_master_seq_if.sv
// Bundle of host handshake, shift-register control and SPI pin signals for spi_master_seq.
// The sequencer uses the master view; the host and shift-register model use the slave view.
interface spi_master_seq_if;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] tx_data_i;
    logic       tx_last_i;
    logic [7:0] tx_byte_o;
    logic       tx_load_byte_en_o;
    logic       tx_load_bit_en_o;
    logic       rx_load_bit_en_o;
    logic [7:0] rx_byte_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       sclk_o;
    logic       cs_n_o;
    logic       busy_o;

    modport master (
        input  tx_valid_i, tx_data_i, tx_last_i, rx_byte_i,
        output tx_ready_o, tx_byte_o, tx_load_byte_en_o, tx_load_bit_en_o,
        output rx_load_bit_en_o, rx_data_o, rx_valid_o, sclk_o, cs_n_o, busy_o
    );

    modport slave (
        output tx_valid_i, tx_data_i, tx_last_i, rx_byte_i,
        input  tx_ready_o, tx_byte_o, tx_load_byte_en_o, tx_load_bit_en_o,
        input  rx_load_bit_en_o, rx_data_o, rx_valid_o, sclk_o, cs_n_o, busy_o
    );
endinterface

// File: rtl/spi_master_seq.sv
// SPI transfer sequencer: turns host byte requests into 8-bit SPI transfers by driving
// sclk, chip select and the load/shift enables of an external write/read shift-register pair.
module spi_master_seq #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    spi_master_seq_if.master  bus
);
    localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_CNT = (MAX_AB > CS_HOLD) ? MAX_AB : CS_HOLD;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int HOLD_M2 = (CS_HOLD > 1) ? (CS_HOLD - 2) : 0;

    localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_M1 = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_M2);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOAD, S_LOW, S_HIGH, S_DONE, S_HOLD, S_WAIT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic             r_last;
    logic [7:0]       r_tx_byte, r_rx_data;
    logic             r_tx_ready, r_rx_valid, r_sclk, r_cs_n, r_busy;
    logic             r_byte_en, r_bit_en, r_rx_en;
    logic             w_byte_en_nxt, w_bit_en_nxt, w_rx_en_nxt;
    logic             w_accept, w_phase_end, w_first;

    assign w_accept    = bus.tx_valid_i && r_tx_ready;
    assign w_phase_end = (r_cnt == CNT_ZERO);
    assign w_first     = (r_cnt == DIV_M1);

    // Next-state, phase counter and bit counter; every state entry reloads the phase counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = SETUP_M1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP, S_LOAD, S_LOW: begin
                if (w_phase_end) begin
                    w_cnt_nxt = DIV_M1;
                    if (r_state == S_SETUP) begin
                        w_state_nxt = S_LOAD;
                    end else if (r_state == S_LOAD) begin
                        w_state_nxt = S_LOW;
                        w_bit_nxt   = 3'd7;
                    end else begin
                        w_state_nxt = S_HIGH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!w_phase_end) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (r_bit != 3'd0) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = DIV_M1;
                    w_bit_nxt   = r_bit - 3'd1;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // DONE is already the first cycle of the chip-select hold.
                if (!r_last) begin
                    w_state_nxt = S_WAIT;
                end else if (CS_HOLD > 1) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = HOLD_LD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (w_phase_end) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (w_accept) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = DIV_M1;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Enables move only in the second cycle of LOAD/LOW/HIGH, so they never change with sclk.
    always_comb begin
        w_byte_en_nxt = r_byte_en;
        w_bit_en_nxt  = r_bit_en;
        w_rx_en_nxt   = r_rx_en;
        case (r_state)
            S_LOAD: begin
                if (w_first) begin
                    w_byte_en_nxt = 1'b1;
                end else begin
                    w_byte_en_nxt = r_byte_en;
                end
            end
            S_LOW: begin
                if (w_first) begin
                    w_byte_en_nxt = 1'b0;
                    w_bit_en_nxt  = 1'b0;
                    w_rx_en_nxt   = 1'b1;
                end else begin
                    w_rx_en_nxt   = r_rx_en;
                end
            end
            S_HIGH: begin
                if (w_first) begin
                    w_rx_en_nxt  = 1'b0;
                    w_bit_en_nxt = (r_bit != 3'd0);
                end else begin
                    w_bit_en_nxt = r_bit_en;
                end
            end
            default: begin
                w_byte_en_nxt = 1'b0;
                w_bit_en_nxt  = 1'b0;
                w_rx_en_nxt   = 1'b0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_bit   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    // Output registers decoded from the next state so pins line up with the state they belong to.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b1;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_byte_en  <= 1'b0;
            r_bit_en   <= 1'b0;
            r_rx_en    <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_rx_data  <= 8'h00;
            r_last     <= 1'b0;
        end else begin
            r_tx_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT);
            r_rx_valid <= (w_state_nxt == S_DONE);
            r_sclk     <= (w_state_nxt != S_LOW);
            r_cs_n     <= (w_state_nxt == S_IDLE);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_byte_en  <= w_byte_en_nxt;
            r_bit_en   <= w_bit_en_nxt;
            r_rx_en    <= w_rx_en_nxt;
            if (w_accept) begin
                r_tx_byte <= bus.tx_data_i;
                r_last    <= bus.tx_last_i;
            end
            if ((r_state == S_HIGH) && (w_state_nxt == S_DONE)) begin
                r_rx_data <= bus.rx_byte_i;
            end
        end
    end

    assign bus.tx_ready_o        = r_tx_ready;
    assign bus.tx_byte_o         = r_tx_byte;
    assign bus.tx_load_byte_en_o = r_byte_en;
    assign bus.tx_load_bit_en_o  = r_bit_en;
    assign bus.rx_load_bit_en_o  = r_rx_en;
    assign bus.rx_data_o         = r_rx_data;
    assign bus.rx_valid_o        = r_rx_valid;
    assign bus.sclk_o            = r_sclk;
    assign bus.cs_n_o            = r_cs_n;
    assign bus.busy_o            = r_busy;
endmodule

// File: tb/tb_spi_master_seq.sv
// Bench for spi_master_seq: default-parameter and CLK_DIV=2/CS_SETUP=1/CS_HOLD=1 instances,
// each with a looped-back shift-register model and an sclk edge/enable monitor.
module tb_spi_master_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       t_valid = 1'b0;
    logic [7:0] t_data = 8'h00;
    logic       t_last = 1'b0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    spi_master_seq_if bus [2] ();

    spi_master_seq #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(bus[0]));
    spi_master_seq #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus[1]));

    assign bus[0].tx_valid_i = t_valid & ~sel;
    assign bus[1].tx_valid_i = t_valid & sel;
    assign bus[0].tx_data_i  = t_data;
    assign bus[1].tx_data_i  = t_data;
    assign bus[0].tx_last_i  = t_last;
    assign bus[1].tx_last_i  = t_last;

    logic       m_ready, m_rxvalid, m_sclk, m_csn, m_busy;
    logic [7:0] m_txbyte, m_rxdata;
    logic [2:0] m_en;
    assign m_ready   = sel ? bus[1].tx_ready_o : bus[0].tx_ready_o;
    assign m_rxvalid = sel ? bus[1].rx_valid_o : bus[0].rx_valid_o;
    assign m_sclk    = sel ? bus[1].sclk_o     : bus[0].sclk_o;
    assign m_csn     = sel ? bus[1].cs_n_o     : bus[0].cs_n_o;
    assign m_busy    = sel ? bus[1].busy_o     : bus[0].busy_o;
    assign m_txbyte  = sel ? bus[1].tx_byte_o  : bus[0].tx_byte_o;
    assign m_rxdata  = sel ? bus[1].rx_data_o  : bus[0].rx_data_o;
    assign m_en      = sel ? {bus[1].tx_load_byte_en_o, bus[1].tx_load_bit_en_o, bus[1].rx_load_bit_en_o}
                           : {bus[0].tx_load_byte_en_o, bus[0].tx_load_bit_en_o, bus[0].rx_load_bit_en_o};

    // Per-instance loopback shift registers (MOSI wired to MISO) and sclk edge/enable monitor.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic       p_sclk = 1'b1;
        logic [2:0] p_en = 3'b000;
        int         n_fall = 0;
        int         n_rise = 0;
        int         mon_checks = 0;
        int         mon_fail = 0;
        logic [7:0] w_sr = 8'h00;
        logic [7:0] r_sr = 8'h00;

        assign bus[g].rx_byte_i = r_sr;

        always @(negedge clk) begin
            int e;
            int c;
            logic [2:0] en;
            e = 0;
            c = 0;
            en = {bus[g].tx_load_byte_en_o, bus[g].tx_load_bit_en_o, bus[g].rx_load_bit_en_o};
            if (rst) begin
                p_sclk <= 1'b1;
                p_en   <= 3'b000;
                n_fall <= 0;
                n_rise <= 0;
            end else begin
                if (bus[g].sclk_o != p_sclk) begin
                    c++;
                    if (en != p_en) begin
                        e++;
                        $display("FAIL mon%0d en_stable: enables %b at sclk edge, required %b", g, en, p_en);
                    end
                    if (!bus[g].sclk_o) begin
                        c++;
                        if ((en[2] != (n_fall == 0)) || (en[1] != (n_fall != 0))) begin
                            e++;
                            $display("FAIL mon%0d negedge_en: fall %0d byte_en=%b bit_en=%b", g, n_fall, en[2], en[1]);
                        end
                        if (en[2]) w_sr <= bus[g].tx_byte_o;
                        else if (en[1]) w_sr <= {w_sr[6:0], 1'b0};
                        n_fall <= n_fall + 1;
                    end else begin
                        c++;
                        if (!en[0]) begin
                            e++;
                            $display("FAIL mon%0d posedge_en: rx_en=%b required 1", g, en[0]);
                        end
                        if (en[0]) r_sr <= {r_sr[6:0], w_sr[7]};
                        n_rise <= n_rise + 1;
                    end
                end
                if (bus[g].rx_valid_o) begin
                    c++;
                    if ((n_fall != 8) || (n_rise != 8)) begin
                        e++;
                        $display("FAIL mon%0d edge_count: falls=%0d rises=%0d required 8/8", g, n_fall, n_rise);
                    end
                    n_fall <= 0;
                    n_rise <= 0;
                end
                p_sclk <= bus[g].sclk_o;
                p_en   <= en;
            end
            mon_checks <= mon_checks + c;
            mon_fail   <= mon_fail + e;
        end
    end

    typedef struct {
        logic       sel;
        logic [7:0] data;
        logic       last;
        logic [7:0] exp_rx;
        logic       exp_cs;
        int         exp_lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        logic r;
        bit   done;
        done = 1'b0;
        t_data  = d;
        t_last  = l;
        t_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            r = m_ready;
            tick();
            done = r;
        end
        t_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rx(output logic [7:0] d, output int lat, output int cs_hi);
        lat = 0;
        cs_hi = 0;
        while (!m_rxvalid && lat < 300) begin
            if (m_csn) cs_hi++;
            tick();
            lat++;
        end
        d = m_rxdata;
        if (!m_rxvalid) check("rx_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] exp_byte;
        logic [7:0] q [$];
        logic       p, r;
        int lat, cs_hi, viol, viol2, viol3, acc, nrx, nf, nr, ff, lr, rxk, csk, rdk, nv;
        int exp_t [2][4];

        vecs[0] = '{1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0, 70};
        vecs[1] = '{1'b0, 8'hC3, 1'b1, 8'hC3, 1'b1, 68};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 70};
        vecs[3] = '{1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 70};
        vecs[4] = '{1'b0, 8'h81, 1'b1, 8'h81, 1'b1, 68};
        vecs[5] = '{1'b1, 8'h5A, 1'b0, 8'h5A, 1'b0, 35};
        vecs[6] = '{1'b1, 8'h96, 1'b1, 8'h96, 1'b1, 34};
        vecs[7] = '{1'b1, 8'h01, 1'b1, 8'h01, 1'b1, 35};
        // first fall, last rise, rx_valid, cs_n release (cycles after accept)
        exp_t[0] = '{7, 67, 71, 73};
        exp_t[1] = '{4, 34, 36, 37};

        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", 32'(m_sclk), 32'd1);
        check("rst_cs_n", 32'(m_csn), 32'd1);
        check("rst_ready", 32'(m_ready), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_en", 32'(m_en), 32'd0);
        check("rst_rx_valid", 32'(m_rxvalid), 32'd0);
        check("rst_tx_byte", 32'(m_txbyte), 32'd0);
        check("rst_rx_data", 32'(m_rxdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(m_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].sel;
            send_byte(vecs[i].data, vecs[i].last);
            wait_rx(d, lat, cs_hi);
            check($sformatf("vec%0d_rx", i), 32'(d), 32'(vecs[i].exp_rx));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_cs_low", i), 32'(cs_hi), 32'd0);
            repeat (3) tick();
            check($sformatf("vec%0d_cs_after", i), 32'(m_csn), 32'(vecs[i].exp_cs));
            check($sformatf("vec%0d_ready", i), 32'(m_ready), 32'd1);
        end

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            send_byte(8'hA5, 1'b1);
            check($sformatf("t%0d_cs_first", s), 32'(m_csn), 32'd0);
            p = 1'b1; nf = 0; nr = 0; ff = 0; lr = 0; rxk = 0; csk = 0; rdk = 0; d = 8'h00;
            for (int k = 1; k <= 80; k++) begin
                if (p && !m_sclk) begin nf++; if (ff == 0) ff = k; end
                if (!p && m_sclk) begin nr++; lr = k; end
                if (m_rxvalid) begin rxk = k; d = m_rxdata; end
                if (m_csn && csk == 0) begin csk = k; rdk = 32'(m_ready); end
                p = m_sclk;
                tick();
            end
            check($sformatf("t%0d_first_fall", s), 32'(ff), 32'(exp_t[s][0]));
            check($sformatf("t%0d_last_rise", s), 32'(lr), 32'(exp_t[s][1]));
            check($sformatf("t%0d_rx_valid_at", s), 32'(rxk), 32'(exp_t[s][2]));
            check($sformatf("t%0d_cs_up_at", s), 32'(csk), 32'(exp_t[s][3]));
            check($sformatf("t%0d_ready_at_cs_up", s), 32'(rdk), 32'd1);
            check($sformatf("t%0d_edges", s), 32'({nf[15:0], nr[15:0]}), {16'd8, 16'd8});
            check($sformatf("t%0d_rx", s), 32'(d), 32'hA5);
        end

        sel = 1'b0;
        send_byte(8'h69, 1'b0);
        wait_rx(d, lat, cs_hi);
        check("stall_rx0", 32'(d), 32'h69);
        tick();
        viol = 0;
        for (int k = 0; k < 100; k++) begin
            if (m_csn || !m_sclk || (m_en != 3'b000) || !m_ready || !m_busy) viol++;
            tick();
        end
        check("stall_wait_viol", 32'(viol), 32'd0);
        send_byte(8'h96, 1'b1);
        wait_rx(d, lat, cs_hi);
        check("stall_rx1", 32'(d), 32'h96);
        check("stall_rx1_lat", 32'(lat), 32'd68);
        repeat (4) tick();

        t_last = 1'b1;
        t_valid = 1'b1;
        exp_byte = m_txbyte;
        viol = 0; viol2 = 0; viol3 = 0; acc = 0; nrx = 0;
        for (int c = 1; c <= 170; c++) begin
            t_data = 8'((c * 37) + 5);
            r = m_ready;
            d = t_data;
            tick();
            if (r) begin exp_byte = d; q.push_back(d); acc++; end
            if (m_txbyte != exp_byte) viol++;
            if (m_rxvalid) begin
                nrx++;
                if (q.size() == 0 || m_rxdata != q.pop_front()) viol2++;
            end
            if (m_ready == m_busy) viol3++;
        end
        t_valid = 1'b0;
        check("bp_tx_byte_hold", 32'(viol), 32'd0);
        check("bp_rx_data", 32'(viol2), 32'd0);
        check("bp_ready_vs_busy", 32'(viol3), 32'd0);
        check("bp_accepts", 32'(acc), 32'd3);
        check("bp_rx_count", 32'(nrx), 32'd2);
        wait_rx(d, lat, cs_hi);
        check("bp_last_rx", 32'(d), (q.size() > 0) ? 32'(q.pop_front()) : 32'h1FF);

        send_byte(8'h55, 1'b1);
        nf = 0;
        for (int k = 0; k < 200 && nf < 5; k++) begin
            p = m_sclk;
            tick();
            if (p && !m_sclk) nf++;
        end
        check("abort_reached_bit3", 32'(nf), 32'd5);
        #1;
        rst = 1'b1;
        #1;
        check("abort_sclk", 32'(m_sclk), 32'd1);
        check("abort_cs_n", 32'(m_csn), 32'd1);
        check("abort_en", 32'(m_en), 32'd0);
        check("abort_busy", 32'(m_busy), 32'd0);
        check("abort_ready", 32'(m_ready), 32'd0);
        nv = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("abort_ready_after", 32'(m_ready), 32'd1);
        for (int k = 0; k < 80; k++) begin
            if (m_rxvalid) nv++;
            tick();
        end
        check("abort_no_rx_valid", 32'(nv), 32'd0);
        check("abort_rx_data", 32'(m_rxdata), 32'd0);
        send_byte(8'h0F, 1'b1);
        wait_rx(d, lat, cs_hi);
        check("abort_new_rx", 32'(d), 32'h0F);
        repeat (4) tick();

        check("mon0_active", 32'(g_mon[0].mon_checks > 0), 32'd1);
        check("mon1_active", 32'(g_mon[1].mon_checks > 0), 32'd1);
        check("mon0_fail", 32'(g_mon[0].mon_fail), 32'd0);
        check("mon1_fail", 32'(g_mon[1].mon_fail), 32'd0);
        checks = checks + g_mon[0].mon_checks + g_mon[1].mon_checks;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
